pattern_detector_param: RTL
===========================

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 The module SHALL provide these parameters, one per line:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- DEFAULT_PAT, 4'b1011, pattern held from reset; PAT_LEN bits wide.
- CNT_W, 8, width of the match counter.

REQ-002 The module SHALL provide these ports, one per line:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- in  input  1  serial data bit, sampled on rising clk when en=1.
- en  input  1  bit-valid qualifier; en=0 means no bit this cycle.
- load  input  1  one-cycle strobe; captures pattern and flushes history.
- pattern  input  PAT_LEN  new pattern, sampled only when load=1.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- out  output  1  registered Moore match flag.
- match_count  output  CNT_W  saturating count of matches since reset or load.

Function
REQ-003 The block SHALL be a Moore machine: out and match_count are register outputs and never depend combinationally on any input.

REQ-004 Internal state SHALL consist of:
- pat_reg[PAT_LEN-1:0], the active pattern;
- hist[PAT_LEN-2:0], the last PAT_LEN-1 accepted bits;
- fill, a 0..PAT_LEN-1 count of valid bits in hist;
- out;
- match_count.

REQ-005 Bit order SHALL be MSB-first: the earliest bit of a candidate window is compared with pat_reg[PAT_LEN-1], and the current bit with pat_reg[0].

REQ-006 On an accepted bit (en=1, load=0), match SHALL be true when fill = PAT_LEN-1 and {hist, in} = pat_reg.

REQ-007 On an accepted bit, hist SHALL shift left with in entering at bit 0.

REQ-008 On an accepted bit, fill SHALL:
- increment, saturating at PAT_LEN-1, when there is no match;
- hold at PAT_LEN-1 when there is a match and overlap=1;
- clear to 0 when there is a match and overlap=0, so that no bit of the matched window is reused.

REQ-009 out SHALL take the value of match on the edge that accepts the final pattern bit, and go high for exactly one cycle per match: latency is one clock from sampling the last bit.

REQ-010 On any cycle with en=0 and load=0, out SHALL be 0, and hist, fill, pat_reg and match_count SHALL hold.

REQ-011 match_count SHALL increment by 1 on each match and saturate at 2^CNT_W-1; it shall never wrap.

REQ-012 On load=1, regardless of en:
- pat_reg takes pattern;
- hist, fill, out and match_count clear to 0;
- any bit presented in that cycle is discarded. Load wins over en.

REQ-013 A change of overlap mid-stream SHALL take effect on the next accepted bit; no history is flushed.

REQ-014 Consecutive matches in overlap mode SHALL give out high on consecutive en cycles where the pattern permits it (for example, pattern 1111 with a stream of all ones).

Reset
REQ-015 While reset=0, asynchronously: pat_reg=DEFAULT_PAT, hist=0, fill=0, out=0, match_count=0.

REQ-016 Reset asserted mid-window SHALL discard the partial window: the first match after release requires PAT_LEN fresh accepted bits.

REQ-017 On release, the first accepted bit SHALL be sampled on the first rising clk edge with reset=1.

Verification
REQ-018 Default pattern 1011, overlap=0, stream 1,0,0,0,1,0,1,1,0,0,1,1,1 with en=1 every cycle -> out=1 only in the cycle after the 8th bit; final match_count=1.

REQ-019 load with pattern=3'b101 (PAT_LEN=3 build), stream 1,0,1,0,1:
- overlap=1 -> out pulses after bits 3 and 5, match_count=2;
- overlap=0 -> out pulses after bit 3 only, match_count=1.

REQ-020 Pattern 1011, stream 1,0,1,1 with en=0 for two cycles inserted between bits 2 and 3 -> single match after bit 4; out=0 during the en=0 cycles.

REQ-021 Assert load during the 3rd bit of a 1011 window -> that bit is discarded, match_count=0, out=0; no match until 4 new bits matching the new pattern have been accepted.

REQ-022 Drop reset low mid-window (after bits 1,0,1) -> out=0, match_count=0 immediately without a clock edge, pat_reg=DEFAULT_PAT; a following lone 1 gives no match.

REQ-023 CNT_W=2 build, pattern 1111, overlap=1, all ones for 10 cycles -> out high from the 4th bit-cycle onward, match_count saturates at 3.

Source files
------------

// File: rtl/pattern_detector_param.sv
// Serial MSB-first pattern detector with loadable pattern, overlap control and a
// saturating match counter. All outputs are registered (Moore).
module pattern_detector_param #(
  parameter int                   PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0]   DEFAULT_PAT = 4'b1011,
  parameter int                   CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               en,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int               FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q,  out_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic [PAT_LEN-1:0] window;
  logic               accept;
  logic               match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
    return (v == FILL_MAX) ? v : v + 1'b1;
  endfunction

  // Oldest history bit lines up with pat_q MSB, the incoming bit with pat_q[0].
  assign window = {hist_q, in};
  assign accept = en & ~load;
  assign match  = accept && (fill_q == FILL_MAX) && (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    if (load) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      hist_d = window[PAT_LEN-2:0];
      out_d  = match;
      if (match) begin
        cnt_d = sat_inc(cnt_q);
        // Non-overlapping mode forgets the matched window entirely.
        fill_d = overlap ? fill_q : '0;
      end else begin
        fill_d = fill_inc(fill_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;

endmodule
